// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Purpose  : Loads a program into the core's instruction memory from a byte
//            stream, then releases the core PC reset.
//
//            The stream starts with a 2-byte word count N (LSB first). It is
//            followed by 4*N data bytes, and each word is sent LSB first.
//            Each assembled word is written through the instruction-memory
//            write port at byte address {index, 2'b00}. The core runs only
//            after the last word has been stored.
//
// Ports    : clk       system clock, all state changes on the rising edge
//            reset     synchronous reset, active low
//            start     single-cycle pulse, begins a load from IDLE/RUN/ERR
//            in_data   stream byte
//            in_valid  in_data valid
//            in_ready  loader accepts a byte this cycle
//            we0       instruction-memory write enable
//            wr_addr0  instruction-memory byte address
//            wr_din0   instruction word
//            resetpc   0 holds the core PC at 0, 1 lets the core run
//            busy      load in progress
//            done      program loaded, core running
//            err       bad header (N == 0 or N > MAX_WORDS)
//
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              we0,
    output logic [ADDR_W-1:0] wr_addr0,
    output logic [31:0]       wr_din0,
    output logic              resetpc,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Word-index width and memory capacity in words.
    localparam int               c_IDX_W     = ADDR_W - 2;
    localparam logic [CNT_W:0]   c_MAX_WORDS = (CNT_W + 1)'(1) << c_IDX_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR0  = 3'd1,
        S_HDR1  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_RUN   = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [7:0]          r_cnt_lo;     // header low byte, held until HDR1
    logic [CNT_W-1:0]    r_cnt;        // word count N
    logic [c_IDX_W-1:0]  r_idx;        // index of the word being assembled
    logic [1:0]          r_lane;       // next byte lane inside the word
    logic [23:0]         r_asm;        // bytes 0..2 of the current word
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [31:0]         r_wr_din;

    logic                w_rx_state;
    logic                w_xfer;
    logic [CNT_W-1:0]    w_hdr_cnt;
    logic                w_hdr_bad;
    logic                w_last_word;

    // ------------------------------------------------------------------
    // Status decode. All outputs are functions of the state register only.
    // This keeps them glitch-free, and none depends combinationally on
    // in_valid/start.
    // ------------------------------------------------------------------
    assign w_rx_state = (r_state == S_HDR0) || (r_state == S_HDR1) ||
                        (r_state == S_DATA);
    assign w_xfer     = in_valid & w_rx_state;

    assign in_ready   = w_rx_state;
    assign busy       = w_rx_state || (r_state == S_WRITE);
    assign we0        = (r_state == S_WRITE);
    assign resetpc    = (r_state == S_RUN);
    assign done       = (r_state == S_RUN);
    assign err        = (r_state == S_ERR);
    assign wr_addr0   = r_wr_addr;
    assign wr_din0    = r_wr_din;

    // The full count is formed from the byte arriving in HDR1 and the
    // latched low byte. This lets the range check happen on the same edge.
    assign w_hdr_cnt  = CNT_W'({in_data, r_cnt_lo});
    assign w_hdr_bad  = (w_hdr_cnt == '0) || ({1'b0, w_hdr_cnt} > c_MAX_WORDS);

    // The comparison is done in count width. This way a full-capacity load
    // (index 127, N = 128) does not wrap the narrower index.
    assign w_last_word = ((CNT_W'(r_idx) + CNT_W'(1)) == r_cnt);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_HDR0;
                end
            end
            S_HDR0: begin
                if (w_xfer) begin
                    w_next_state = S_HDR1;
                end
            end
            S_HDR1: begin
                if (w_xfer) begin
                    w_next_state = w_hdr_bad ? S_ERR : S_DATA;
                end
            end
            S_DATA: begin
                if (w_xfer && (r_lane == 2'd3)) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                w_next_state = w_last_word ? S_RUN : S_DATA;
            end
            S_RUN: begin
                if (start) begin
                    w_next_state = S_HDR0;
                end
            end
            S_ERR: begin
                if (start) begin
                    w_next_state = S_HDR0;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: header capture, word assembly, write-port registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt_lo  <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_lane    <= '0;
            r_asm     <= '0;
            r_wr_addr <= '0;
            r_wr_din  <= '0;
        end else begin
            case (r_state)
                S_HDR0: begin
                    if (w_xfer) begin
                        r_cnt_lo <= in_data;
                    end
                end
                S_HDR1: begin
                    if (w_xfer) begin
                        r_cnt  <= w_hdr_cnt;
                        r_idx  <= '0;
                        r_lane <= '0;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        // Lane 3 wraps back to 0, ready for the next word.
                        r_lane <= r_lane + 2'd1;
                        case (r_lane)
                            2'd0: r_asm[7:0]   <= in_data;
                            2'd1: r_asm[15:8]  <= in_data;
                            2'd2: r_asm[23:16] <= in_data;
                            default: begin
                                // The last byte goes straight into the write
                                // register. The WRITE cycle then presents
                                // the complete word without an extra stage.
                                r_wr_addr <= {r_idx, 2'b00};
                                r_wr_din  <= {in_data, r_asm};
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    // The index stops at N-1, so it never passes the
                    // last stored word.
                    if (!w_last_word) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
